mac_tx_framer: RTL

MAC_TX_FRAMER -- requirements
Module: mac_tx_framer

---
 rtl/mac_tx_framer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mac_tx_framer.sv
// Ethernet transmit framer: wraps a payload byte stream with preamble/SFD, zero padding,
// CRC-32 FCS and an enforced inter-frame gap on a GMII-style byte interface.
module mac_tx_framer #(
    parameter int MIN_FRAME = 60,
    parameter int IFG_BYTES = 12
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       tx_er,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG} state_e;

    // IDLE already registers the first 0x55, so PREAMBLE itself supplies the other six.
    localparam logic [15:0] PRE_LAST = 16'd5;
    localparam logic [15:0] FCS_LAST = 16'd3;
    localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);
    localparam logic [11:0] MIN_F    = 12'(MIN_FRAME);
    localparam state_e      POST_TX  = (IFG_BYTES == 0) ? IDLE : IFG;

    state_e      state_q, state_d;
    logic [15:0] cyc_q, cyc_d;
    logic [10:0] bcnt_q, bcnt_d, bcnt_inc;
    logic [31:0] crc_q, crc_d, crc_sh;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_en_q, tx_en_d, tx_er_q, tx_er_d, busy_q;

    // Reflected-input CRC-32: LSB of the byte enters the MSB-first shifter first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ b[i]) c = {c[30:0], 1'b0} ^ 32'h04C11DB7;
            else              c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    assign bcnt_inc = (&bcnt_q) ? bcnt_q : bcnt_q + 11'd1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            bcnt_q    <= '0;
            crc_q     <= '1;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
            tx_er_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bcnt_q    <= bcnt_d;
            crc_q     <= crc_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            tx_er_q   <= tx_er_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bcnt_d  = bcnt_q;
        crc_d   = crc_q;
        unique case (state_q)
            IDLE: if (s_valid) begin
                state_d = PREAMBLE;
                cyc_d   = '0;
            end
            PREAMBLE: if (cyc_q == PRE_LAST) state_d = SFD;
                      else                   cyc_d   = cyc_q + 16'd1;
            SFD: begin
                state_d = DATA;
                crc_d   = '1;
                bcnt_d  = '0;
            end
            DATA: if (s_valid) begin
                crc_d  = crc_byte(crc_q, s_data);
                bcnt_d = bcnt_inc;
                if (s_last) begin
                    cyc_d   = '0;
                    state_d = (({1'b0, bcnt_q} + 12'd1) < MIN_F) ? PAD : FCS;
                end
            end else begin
                cyc_d   = '0;
                state_d = POST_TX;
            end
            PAD: begin
                crc_d  = crc_byte(crc_q, 8'h00);
                bcnt_d = bcnt_inc;
                if (({1'b0, bcnt_q} + 12'd1) >= MIN_F) begin
                    cyc_d   = '0;
                    state_d = FCS;
                end
            end
            FCS: if (cyc_q == FCS_LAST) begin
                cyc_d   = '0;
                state_d = POST_TX;
            end else cyc_d = cyc_q + 16'd1;
            IFG: if (cyc_q == IFG_LAST) begin
                cyc_d   = '0;
                state_d = IDLE;
            end else cyc_d = cyc_q + 16'd1;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_data_d = 8'h00;
        tx_en_d   = 1'b0;
        tx_er_d   = 1'b0;
        crc_sh    = crc_q << {cyc_q[1:0], 3'b000};
        unique case (state_q)
            IDLE: if (s_valid) begin
                tx_en_d   = 1'b1;
                tx_data_d = 8'h55;
            end
            PREAMBLE: begin
                tx_en_d   = 1'b1;
                tx_data_d = 8'h55;
            end
            SFD: begin
                tx_en_d   = 1'b1;
                tx_data_d = 8'hD5;
            end
            DATA: begin
                tx_en_d = 1'b1;
                if (s_valid) tx_data_d = s_data;
                else         tx_er_d   = 1'b1;
            end
            PAD: tx_en_d = 1'b1;
            FCS: begin
                tx_en_d   = 1'b1;
                tx_data_d = ~bitrev8(crc_sh[31:24]);
            end
            default: ;
        endcase
    end

    assign s_ready = (state_q == DATA);
    assign tx_data = tx_data_q;
    assign tx_en   = tx_en_q;
    assign tx_er   = tx_er_q;
    assign busy    = busy_q;
endmodule
